// File: rtl/voice_mixer_if.sv
// Mixer bus: sample tick and per-voice inputs in, mixed sample and status out.
// Voice i occupies bits [16*i+15:16*i] of the sample and envelope buses.
interface voice_mixer_if #(
  parameter int NUM_VOICES = 8
);
  logic                      sample_tick_in;
  logic [16*NUM_VOICES-1:0]  voice_sample_in;
  logic [16*NUM_VOICES-1:0]  envelope_in;
  logic [NUM_VOICES-1:0]     voice_active_in;
  logic [15:0]               mix_out;
  logic                      mix_valid;
  logic                      busy;
  logic [4:0]                active_count;
  logic                      tick_overrun;

  modport master (
    output sample_tick_in, voice_sample_in, envelope_in, voice_active_in,
    input  mix_out, mix_valid, busy, active_count, tick_overrun
  );

  modport slave (
    input  sample_tick_in, voice_sample_in, envelope_in, voice_active_in,
    output mix_out, mix_valid, busy, active_count, tick_overrun
  );
endinterface

// File: rtl/voice_mixer.sv
// Envelope-weighted voice mixer with one shared multiplier; result NUM_VOICES+2 edges after the tick.
// No backpressure: ticks arriving while a pass runs are dropped and flagged in sticky tick_overrun.
module voice_mixer #(
  parameter int NUM_VOICES = 8,
  parameter int MIX_SHIFT  = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  voice_mixer_if.slave bus
);
  localparam int IDXW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACCW = 18 + $clog2(NUM_VOICES);
  localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(NUM_VOICES - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SAT_MIN  = ACCW'(-32768);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [16*NUM_VOICES-1:0]  r_samp;
  logic [16*NUM_VOICES-1:0]  r_env;
  logic [NUM_VOICES-1:0]     r_act;
  logic [IDXW-1:0]           r_idx;
  logic signed [17:0]        r_prod;
  logic                      r_prod_vld;
  logic signed [ACCW-1:0]    r_acc;
  logic [15:0]               r_mix;
  logic                      r_mix_vld;
  logic [4:0]                r_cnt;
  logic                      r_ovr;

  logic signed [15:0]        w_samp;
  logic [15:0]               w_env;
  logic signed [32:0]        w_prod_full;
  logic signed [17:0]        w_prod;
  logic signed [ACCW-1:0]    w_shift;
  logic [15:0]               w_sat;
  logic [4:0]                w_pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.sample_tick_in) w_next = S_MAC;
      S_MAC:   if (r_idx == LAST_IDX)  w_next = S_DRAIN;
      S_DRAIN: w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Envelope is unsigned, so it is zero-extended to keep the product signed at 33 bits.
  assign w_samp      = r_samp[16*r_idx +: 16];
  assign w_env       = r_env[16*r_idx +: 16];
  assign w_prod_full = w_samp * $signed({1'b0, w_env});
  assign w_prod      = w_prod_full[32:15];
  assign w_shift     = r_acc >>> MIX_SHIFT;

  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > SAT_MAX)      w_sat = 16'h7FFF;
    else if (w_shift < SAT_MIN) w_sat = 16'h8000;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) w_pop = w_pop + 5'(bus.voice_active_in[i]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_samp     <= '0;
      r_env      <= '0;
      r_act      <= '0;
      r_idx      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_mix      <= '0;
      r_mix_vld  <= 1'b0;
      r_cnt      <= '0;
      r_ovr      <= 1'b0;
    end else begin
      r_mix_vld  <= 1'b0;
      r_prod_vld <= 1'b0;
      if (r_state != S_IDLE && bus.sample_tick_in) r_ovr <= 1'b1;
      // Accumulate trails the multiplier by one cycle; the last one lands in DRAIN.
      if (r_prod_vld) r_acc <= r_acc + ACCW'(r_prod);
      case (r_state)
        S_IDLE: begin
          if (bus.sample_tick_in) begin
            r_samp <= bus.voice_sample_in;
            r_env  <= bus.envelope_in;
            r_act  <= bus.voice_active_in;
            r_cnt  <= w_pop;
            r_idx  <= '0;
            r_acc  <= '0;
          end
        end
        S_MAC: begin
          r_prod     <= r_act[r_idx] ? w_prod : '0;
          r_prod_vld <= 1'b1;
          r_idx      <= r_idx + IDXW'(1);
        end
        S_OUT: begin
          r_mix     <= w_sat;
          r_mix_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mix_out      = r_mix;
  assign bus.mix_valid    = r_mix_vld;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.active_count = r_cnt;
  assign bus.tick_overrun = r_ovr;
endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Downstream stage of the per-voice envelope generators.
- Multiplies each voice's signed oscillator sample by that voice's 16-bit envelope, then sums the results over all voices.
- Scales and saturates the sum to one signed 16-bit audio sample, once per audio-rate tick.
- Uses one shared multiplier, time-multiplexed over the voices. The result feeds the audio output/DAC path.

Parameters:
- NUM_VOICES, 8, number of voices mixed (1..16).
- MIX_SHIFT, 3, arithmetic right shift applied to the accumulated sum before saturation.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- sample_tick_in  input  1  one-cycle pulse at audio sample rate; starts one mix pass.
- voice_sample_in  input  16*NUM_VOICES  signed two's-complement samples; voice i at [16*i+15:16*i].
- envelope_in  input  16*NUM_VOICES  unsigned envelope per voice (0x8000 = unity gain); voice i at [16*i+15:16*i].
- voice_active_in  input  NUM_VOICES  1 = voice contributes (driven from ~adsr_idle).
- mix_out  output  16  signed mixed sample; holds its value between passes.
- mix_valid  output  1  one-cycle pulse when mix_out updates.
- busy  output  1  high while a pass is in progress.
- active_count  output  5  number of active voices captured at the last tick.
- tick_overrun  output  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE; mix_out=0, mix_valid=0, busy=0, active_count=0, tick_overrun=0; accumulator, index and pipeline registers cleared.
- Reset asserted mid-pass aborts the pass: no mix_valid is produced and mix_out returns to 0.
- States: IDLE, MAC, DRAIN, OUT.
- IDLE: on the edge where sample_tick_in=1:
  - snapshot voice_sample_in, envelope_in and voice_active_in into internal registers;
  - set active_count = popcount of the captured voice_active_in;
  - idx=0, acc=0, go to MAC.
  - Later input changes do not affect the pass in progress.
- MAC, multiplier stage, one voice per cycle:
  - prod_reg <= captured active[idx] ? (sample[idx] * {1'b0, env[idx]}) >>> 15 : 0;
  - the product is computed signed at 33 bits; the shift is arithmetic, i.e. floor rounding;
  - idx increments each cycle; after idx = NUM_VOICES-1 go to DRAIN.
- Accumulate stage, the cycle after each product: acc <= acc + prod_reg.
  - prod_reg is 18-bit signed; acc is 18+clog2(NUM_VOICES) bits signed, so it can never overflow.
- DRAIN: the final accumulate happens in this cycle; go to OUT.
- OUT:
  - r = acc >>> MIX_SHIFT (arithmetic);
  - mix_out <= 32767 if r > 32767; -32768 if r < -32768; else r[15:0];
  - mix_valid <= 1 for exactly one cycle; return to IDLE.
- Latency: tick sampled at edge T → mix_valid and the new mix_out are visible after edge T+NUM_VOICES+2. One pass takes NUM_VOICES+3 cycles from tick to back in IDLE.
- busy = (state != IDLE).
- A tick accepted in IDLE shows busy=1 after the same edge.
- sample_tick_in while busy, including in the OUT cycle:
  - the tick is ignored and the current pass is unaffected;
  - tick_overrun is set to 1 and stays set until reset.
- Envelope 0 or inactive voice → contributes exactly 0. Envelope 0xFFFF → gain of about 2 is allowed; the 18-bit product holds it.
- A pass with all voices inactive produces mix_out=0 with mix_valid still pulsed.

Test Plan:
- NUM_VOICES=8, MIX_SHIFT=0; only voice 0 active, sample=1000, env=0x8000; tick → mix_valid exactly 10 cycles after the tick edge, mix_out=1000, active_count=1.
- Only voice 3 active, sample=-2000, env=0x4000 → mix_out=-1000. Then sample=-1, env=0x4000 → mix_out=-1 (floor).
- All 8 voices active, sample=32767, env=0xFFFF, MIX_SHIFT=0 → mix_out=32767. Same with sample=-32768 → mix_out=-32768.
- MIX_SHIFT=3; 8 voices active, sample=8000, env=0x8000 → mix_out=8000. Deassert voice_active_in[0..3] before the tick → mix_out=4000, active_count=4.
- Tick, then change all inputs and pulse a second tick 4 cycles later → exactly one mix_valid, result computed from the first snapshot, tick_overrun=1; the next tick in IDLE is processed normally.
- Assert rst_in 5 cycles into a pass → no mix_valid; mix_out=0, busy=0, tick_overrun=0 on the following cycle.
